i2s_rx_writer: RTL and testbench



---
 rtl/i2s_rx_writer_if.sv | 27 ++
 rtl/i2s_rx_writer.sv | 135 +++++++++++++
 tb/tb_i2s_rx_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2s_rx_writer_if.sv
// i2s_rx_writer_if: I2S pins, control and audio-RAM write port of the I2S receiver.
interface i2s_rx_writer_if #(
   parameter int LINES  = 8,
   parameter int FRAMES = 32
);
   localparam int CHAN_W  = $clog2(2 * LINES);
   localparam int FRAME_W = $clog2(FRAMES);
   logic                      en_i;
   logic                      sck_i;
   logic                      ws_i;
   logic [LINES-1:0]          sd_i;
   logic                      clr_error_i;
   logic                      we_o;
   logic [FRAME_W+CHAN_W-1:0] waddr_o;
   logic [15:0]               wdata_o;
   logic [FRAME_W-1:0]        frame_o;
   logic                      frame_done_o;
   logic                      error_o;
   modport master (
      output en_i, sck_i, ws_i, sd_i, clr_error_i,
      input  we_o, waddr_o, wdata_o, frame_o, frame_done_o, error_o
   );
   modport slave (
      input  en_i, sck_i, ws_i, sd_i, clr_error_i,
      output we_o, waddr_o, wdata_o, frame_o, frame_done_o, error_o
   );
endinterface

// File: rtl/i2s_rx_writer.sv
// i2s_rx_writer: I2S multi-line receiver bursting each word into audio RAM; define I2S_RX_FRAMING_EN for slot-length checks.
module i2s_rx_writer #(
   parameter int LINES  = 8,
   parameter int FRAMES = 32,
   parameter int SLOT   = 32
) (
   input logic            ck,
   input logic            rst,
   i2s_rx_writer_if.slave bus
);
   localparam int CHAN_W  = $clog2(2 * LINES);
   localparam int FRAME_W = $clog2(FRAMES);
   localparam int LW      = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CNT_W   = ((SLOT > 16) ? $clog2(SLOT) : 4) + 2;
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   state_t                    state_q, state_d;
   logic [2:0]                sck_q;
   logic [1:0]                ws_q;
   logic [LINES-1:0]          sd1_q, sd2_q;
   logic                      ws_prev_q, ws_prev_d;
   logic                      sync_q, sync_d;
   logic [CNT_W-1:0]          bitcnt_q, bitcnt_d;
   logic [15:0]               shift_q [LINES];
   logic [15:0]               shift_d [LINES];
   logic [15:0]               sh_new  [LINES];
   logic [15:0]               hold_q  [LINES];
   logic [15:0]               hold_d  [LINES];
   logic                      lr_q, lr_d;
   logic [LW-1:0]             idx_q, idx_d;
   logic                      we_q, we_d;
   logic [FRAME_W+CHAN_W-1:0] waddr_q, waddr_d;
   logic [15:0]               wdata_q, wdata_d;
   logic [FRAME_W-1:0]        frame_q, frame_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;
   logic                      sck_rise, wend, take, ovr, frm_err;
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign wend     = sck_rise & (ws_q[1] != ws_prev_q);
   assign take     = wend & sync_q & (state_q == IDLE);
   assign ovr      = wend & sync_q & (state_q != IDLE);
`ifdef I2S_RX_FRAMING_EN
   assign frm_err  = wend & sync_q & (32'(bitcnt_q) + 32'd1 != 32'(SLOT));
`else
   assign frm_err  = 1'b0;
`endif
   // The bit sampled on a word-end edge still belongs to the old word, so the
   // holding copy takes the freshly shifted value and the shifter restarts empty.
   always_comb begin
      for (int k = 0; k < LINES; k++) begin
         sh_new[k]  = (bitcnt_q < CNT_W'(16)) ? {shift_q[k][14:0], sd2_q[k]} : shift_q[k];
         shift_d[k] = !sck_rise ? shift_q[k] : wend ? 16'h0 : sh_new[k];
         hold_d[k]  = take ? sh_new[k] : hold_q[k];
      end
      bitcnt_d  = !sck_rise ? bitcnt_q : wend ? '0 : (&bitcnt_q) ? bitcnt_q : bitcnt_q + 1'b1;
      ws_prev_d = sck_rise ? ws_q[1] : ws_prev_q;
      sync_d    = bus.en_i & (sync_q | wend);
      lr_d      = take ? ws_prev_q : lr_q;
      error_d   = (ovr | frm_err) ? 1'b1 : bus.clr_error_i ? 1'b0 : error_q;
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      frame_d = frame_q;
      case (state_q)
         IDLE: begin
            state_d = take ? WRITE : IDLE;
            idx_d   = '0;
         end
         WRITE: begin
            we_d    = 1'b1;
            waddr_d = {frame_q, CHAN_W'({idx_q, lr_q})};
            wdata_d = hold_q[idx_q];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LW'(LINES - 1)) state_d = lr_q ? DONE : IDLE;
         end
         DONE: begin
            done_d  = 1'b1;
            frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge ck or negedge rst)
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   always_ff @(posedge ck or negedge rst)
      if (!rst) begin
         sck_q     <= '0;
         ws_q      <= '0;
         sd1_q     <= '0;
         sd2_q     <= '0;
         ws_prev_q <= 1'b0;
         sync_q    <= 1'b0;
         bitcnt_q  <= '0;
         shift_q   <= '{default: '0};
         hold_q    <= '{default: '0};
         lr_q      <= 1'b0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         frame_q   <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         sck_q     <= {sck_q[1:0], bus.sck_i};
         ws_q      <= {ws_q[0], bus.ws_i};
         sd1_q     <= bus.sd_i;
         sd2_q     <= sd1_q;
         ws_prev_q <= ws_prev_d;
         sync_q    <= sync_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         hold_q    <= hold_d;
         lr_q      <= lr_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         frame_q   <= frame_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   assign bus.we_o         = we_q;
   assign bus.waddr_o      = waddr_q;
   assign bus.wdata_o      = wdata_q;
   assign bus.frame_o      = frame_q;
   assign bus.frame_done_o = done_q;
   assign bus.error_o      = error_q;
endmodule

// File: tb/tb_i2s_rx_writer.sv
// tb_i2s_rx_writer: directed I2S streams into i2s_rx_writer, with a RAM model fed from the write port.
module tb_i2s_rx_writer;
   localparam int LINES = 8, FRAMES = 32, SLOT = 32;
   logic ck = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0, n_bad = 0, wr_cnt = 0, fd_cnt = 0, n0 = 0, seen = 0;
   logic [15:0] ram [0:511];
   always #5 ck = ~ck;
   i2s_rx_writer_if #(.LINES(LINES), .FRAMES(FRAMES)) bus ();
   i2s_rx_writer #(.LINES(LINES), .FRAMES(FRAMES), .SLOT(SLOT)) dut (.ck(ck), .rst(rst), .bus(bus));
   always @(negedge ck) begin
      if (bus.we_o) begin
         ram[bus.waddr_o] = bus.wdata_o;
         wr_cnt++;
      end
      if (bus.frame_done_o) fd_cnt++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Line k carries base+k; ws flips together with the last bit of the word.
   task automatic send_word(input logic w, input logic [15:0] base, input int nbits, input int h);
      logic [15:0] v;
      for (int i = 0; i < nbits; i++) begin
         @(negedge ck);
         bus.ws_i  = (i == nbits - 1) ? ~w : w;
         for (int k = 0; k < LINES; k++) begin
            v = base + 16'(k);
            bus.sd_i[k] = (i < 16) ? v[15-i] : 1'b0;
         end
         bus.sck_i = 1'b0;
         repeat (h) @(negedge ck);
         bus.sck_i = 1'b1;
         repeat (h - 1) @(negedge ck);
      end
   endtask
   task automatic settle();
      repeat (24) @(negedge ck);
   endtask
   task automatic frame_pair(input logic [15:0] l, input logic [15:0] r);
      send_word(1'b0, l, 32, 4);
      send_word(1'b1, r, 32, 4);
      settle();
   endtask
   task automatic pulse_clr();
      @(negedge ck) bus.clr_error_i = 1'b1;
      @(negedge ck) bus.clr_error_i = 1'b0;
   endtask
   initial begin
      bus.en_i = 1'b0; bus.sck_i = 1'b0; bus.ws_i = 1'b0; bus.sd_i = '0; bus.clr_error_i = 1'b0;
      for (int a = 0; a < 512; a++) ram[a] = 16'h0;
      #1 rst = 1'b0;
      repeat (3) @(negedge ck);
      check("rst_we", bus.we_o, 0);
      check("rst_frame", bus.frame_o, 0);
      check("rst_done", bus.frame_done_o, 0);
      check("rst_error", bus.error_o, 0);
      check("rst_waddr", bus.waddr_o, 0);
      check("rst_wdata", bus.wdata_o, 0);
      rst = 1'b1;
      send_word(1'b0, 16'hAAAA, 32, 4);
      bus.en_i = 1'b1;
      send_word(1'b1, 16'hBBBB, 32, 4);
      settle();
      check("sync_no_write", wr_cnt, 0);
      frame_pair(16'h1000, 16'h2000);
      for (int k = 0; k < LINES; k++) begin
         check("f0_left", ram[2*k], 32'h1000 + k);
         check("f0_right", ram[2*k+1], 32'h2000 + k);
      end
      check("f0_done", fd_cnt, 1);
      check("f0_frame", bus.frame_o, 1);
      check("f0_writes", wr_cnt, 16);
      for (int f = 1; f <= 32; f++) begin
         frame_pair(16'h4000 + 16'(f * 16), 16'h8000 + 16'(f * 16));
         if (f == 31) check("wrap_frame", bus.frame_o, 0);
      end
      check("wrap_ram0", ram[0], 16'h4200);
      check("wrap_ram15", ram[15], 16'h8207);
      check("f31_ch3", ram[31*16+3], 16'h81F1);
      check("f5_ch4", ram[5*16+4], 16'h4052);
      check("stream_done", fd_cnt, 33);
      check("stream_frame", bus.frame_o, 1);
      check("stream_writes", wr_cnt, 528);
      check("stream_error", bus.error_o, 0);
      bus.en_i = 1'b0;
      send_word(1'b0, 16'hCCCC, 32, 4);
      send_word(1'b1, 16'hCCCC, 32, 4);
      send_word(1'b0, 16'hCCCC, 32, 4);
      bus.en_i = 1'b1;
      send_word(1'b1, 16'hDDDD, 32, 4);
      settle();
      check("en_discard", wr_cnt, 528);
      frame_pair(16'h5000, 16'h6000);
      check("en_left0", ram[16], 16'h5000);
      check("en_left7", ram[16+14], 16'h5007);
      check("en_right7", ram[16+15], 16'h6007);
      check("en_frame", bus.frame_o, 2);
      check("en_writes", wr_cnt, 544);
      send_word(1'b0, 16'h7000, 30, 4);
      settle();
`ifdef I2S_RX_FRAMING_EN
      check("framing_err", bus.error_o, 1);
      check("framing_written", ram[32], 16'h7000);
      pulse_clr();
      check("framing_clr", bus.error_o, 0);
`else
      check("framing_noerr", bus.error_o, 0);
      check("framing_written", ram[32], 16'h7000);
`endif
      send_word(1'b1, 16'h7100, 32, 4);
      settle();
      check("framing_frame", bus.frame_o, 3);
      pulse_clr();
      n0 = wr_cnt;
      send_word(1'b0, 16'h8000, 2, 1);
      send_word(1'b1, 16'h4000, 2, 1);
      settle();
      check("ovr_error", bus.error_o, 1);
      check("ovr_writes", wr_cnt - n0, 8);
      check("ovr_left0", ram[48], 16'h0002);
      check("ovr_left7", ram[48+14], 16'h0002);
      check("ovr_right_kept", ram[49], 16'h8030);
      check("ovr_frame", bus.frame_o, 3);
      check("ovr_done", fd_cnt, 35);
      pulse_clr();
      n0 = wr_cnt;
      send_word(1'b0, 16'h9000, 32, 4);
      seen = 0;
      for (int c = 0; c < 60 && seen < 3; c++) begin
         @(negedge ck);
         if (bus.we_o) seen++;
      end
      check("rst_burst_seen", seen, 3);
      #1 rst = 1'b0;
      #1;
      check("rst_burst_we", bus.we_o, 0);
      check("rst_burst_frame", bus.frame_o, 0);
      repeat (3) @(negedge ck);
      rst = 1'b1;
      repeat (20) @(negedge ck);
      check("rst_burst_writes", wr_cnt - n0, 3);
      send_word(1'b1, 16'hA000, 32, 4);
      settle();
      check("resume_right0", ram[1], 16'hA000);
      check("resume_right7", ram[15], 16'hA007);
      check("resume_frame", bus.frame_o, 1);
      check("resume_writes", wr_cnt - n0, 11);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
